// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone B4 pipelined initiator: one command becomes one bus cycle and one response.
// Each rty termination gets a one-cycle cyc drop before the re-issue; every attempt is bounded by a cycle timeout.
module wb_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic                  cmd_we_i,
  input  logic [3:0]            cmd_sel_i,
  input  logic [31:0]           cmd_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_dat_o,
  output logic [1:0]            rsp_status_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i
);

  localparam logic [1:0]  ST_ACK    = 2'b00;
  localparam logic [1:0]  ST_ERR    = 2'b01;
  localparam logic [1:0]  ST_RTY    = 2'b10;
  localparam logic [1:0]  ST_TMO    = 2'b11;
  localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT);
  localparam logic [15:0] RTY_LIMIT = 16'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, BACKOFF, RSP} state_t;

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [15:0] rty_cnt;
  logic        on_bus;
  logic        tmo_hit;
  logic        fin;
  logic        do_retry;
  logic [1:0]  fin_status;
  logic [31:0] fin_dat;

  assign on_bus  = (state == REQ) || (state == WAIT);
  // The current cycle would be the TIMEOUT-th without a termination.
  assign tmo_hit = ({1'b0, tmo_cnt} + 17'd1) >= TMO_LIMIT;

  // Termination decode: err beats rty beats ack, and any termination beats the timeout.
  always_comb begin
    fin        = 1'b0;
    do_retry   = 1'b0;
    fin_status = ST_ACK;
    fin_dat    = '0;
    if (on_bus) begin
      if (wb_err_i) begin
        fin        = 1'b1;
        fin_status = ST_ERR;
      end else if (wb_rty_i) begin
        if (rty_cnt < RTY_LIMIT) begin
          do_retry = 1'b1;
        end else begin
          fin        = 1'b1;
          fin_status = ST_RTY;
        end
      end else if (wb_ack_i) begin
        fin     = 1'b1;
        fin_dat = wb_we_o ? 32'd0 : wb_dat_i;
      end else if (tmo_hit) begin
        fin        = 1'b1;
        fin_status = ST_TMO;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cmd_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_status_o <= ST_ACK;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_sel_o     <= '0;
      wb_dat_o     <= '0;
      tmo_cnt      <= '0;
      rty_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            wb_adr_o    <= cmd_adr_i;
            wb_we_o     <= cmd_we_i;
            wb_sel_o    <= cmd_sel_i;
            wb_dat_o    <= cmd_dat_i;
            tmo_cnt     <= '0;
            rty_cnt     <= '0;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            cmd_ready_o <= 1'b0;
            state       <= REQ;
          end
        end
        REQ, WAIT: begin
          if (fin) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_dat_o    <= fin_dat;
            rsp_status_o <= fin_status;
            state        <= RSP;
          end else if (do_retry) begin
            rty_cnt  <= rty_cnt + 16'd1;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state    <= BACKOFF;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
            // A stalled request keeps stb and the held address/data on the bus.
            if ((state == REQ) && !wb_stall_i) begin
              wb_stb_o <= 1'b0;
              state    <= WAIT;
            end
          end
        end
        BACKOFF: begin
          tmo_cnt  <= '0;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          state    <= REQ;
        end
        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Randomized bench for wb_initiator: a scripted Wishbone slave plus a transaction-level outcome model.
module tb_wb_initiator;
  localparam int TMO  = 8;
  localparam int MAXR = 3;
  localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_ALL = 3, K_NONE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready_o, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid_o, rsp_ready;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;

  always #5 clk = ~clk;

  wb_initiator #(.ADDR_WIDTH(32), .TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_adr_i(cmd_adr),
    .cmd_we_i(cmd_we), .cmd_sel_i(cmd_sel), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat_o),
    .rsp_status_o(rsp_status_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Slave script: per attempt, termination kind, cycle of cyc it lands on, and stall length.
  int          sc_kind[8];
  int          sc_t[8];
  int          sc_stall[8];
  logic [31:0] sc_rdata;
  int          sl_att;

  // Expected transaction outcome.
  logic [31:0] e_adr, e_dat, e_rdat;
  logic [3:0]  e_sel;
  logic        e_we;
  int          e_status, e_att, e_cyc, e_stb, e_lat;

  // Observations gathered by the compare process.
  bit          mon_en = 1'b0;
  bit          prev_cyc = 1'b0;
  bit          rsp_first = 1'b0;
  int          lat = 0, o_att = 0, o_cyc = 0, o_stb = 0, o_rsp_cyc = 0, o_nrsp = 0;
  int          last_status, last_lat;
  logic [31:0] last_dat;
  int          sent = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Outcome of a command from the slave script, attempt by attempt.
  task automatic model(input logic we, input logic [31:0] rd);
    int retry = 0;
    int tt;
    e_att = 0; e_cyc = 0; e_stb = 0; e_rdat = 0; e_status = 0;
    for (int a = 0; a < 8; a++) begin
      e_att++;
      tt = (sc_kind[a] == K_NONE) ? 100000 : sc_t[a];
      if (tt > TMO) begin
        e_cyc += TMO; e_stb += imin(sc_stall[a] + 1, TMO); e_status = 3;
        break;
      end
      e_cyc += tt;
      e_stb += imin(sc_stall[a] + 1, tt);
      if (sc_kind[a] == K_ERR || sc_kind[a] == K_ALL) begin
        e_status = 1;
        break;
      end
      if (sc_kind[a] == K_RTY) begin
        if (retry < MAXR) begin
          retry++;
          continue;
        end
        e_status = 2;
        break;
      end
      e_status = 0;
      e_rdat   = we ? 32'd0 : rd;
      break;
    end
    e_lat = e_cyc + e_att;
  endtask

  // Slave: follows the script while cyc is high, throws junk terminations while it is low.
  initial begin
    int c = 0;
    int idx;
    bit hit;
    wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_stall_i = 0; wb_dat_i = 0;
    forever begin
      @(posedge clk); #1;
      if (wb_cyc_o) begin
        if (c == 0) sl_att++;
        c++;
        idx = (sl_att < 8) ? sl_att : 7;
        hit = (sc_kind[idx] != K_NONE) && (c == sc_t[idx]);
        wb_ack_i   = hit && (sc_kind[idx] == K_ACK || sc_kind[idx] == K_ALL);
        wb_err_i   = hit && (sc_kind[idx] == K_ERR || sc_kind[idx] == K_ALL);
        wb_rty_i   = hit && (sc_kind[idx] == K_RTY || sc_kind[idx] == K_ALL);
        wb_stall_i = wb_stb_o ? (c <= sc_stall[idx]) : 1'($urandom_range(0, 1));
        wb_dat_i   = hit ? sc_rdata : $urandom;
      end else begin
        c = 0;
        wb_ack_i   = ($urandom_range(0, 3) == 0);
        wb_err_i   = ($urandom_range(0, 3) == 0);
        wb_rty_i   = ($urandom_range(0, 3) == 0);
        wb_stall_i = 1'($urandom_range(0, 1));
        wb_dat_i   = $urandom;
      end
    end
  end

  // Compare process: bus contents, response contents, latency and per-transaction counts.
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_cyc = 1'b0;
    end else begin
      lat++;
      if (wb_cyc_o) begin
        o_cyc++;
        if (!prev_cyc) o_att++;
        if (wb_stb_o) o_stb++;
        check("bus_adr", wb_adr_o, e_adr);
        check("bus_dat", wb_dat_o, e_dat);
        check("bus_sel", 32'(wb_sel_o), 32'(e_sel));
        check("bus_we", 32'(wb_we_o), 32'(e_we));
      end
      check("stb_implies_cyc", 32'(wb_stb_o & ~wb_cyc_o), 0);
      if (rsp_valid_o) begin
        o_rsp_cyc++;
        check("rsp_dat", rsp_dat_o, e_rdat);
        check("rsp_status", 32'(rsp_status_o), e_status);
        check("rsp_cyc_low", 32'(wb_cyc_o), 0);
        check("rsp_cmd_ready_low", 32'(cmd_ready_o), 0);
        if (rsp_first) begin
          rsp_first = 1'b0;
          last_lat  = lat;
          check("rsp_latency", lat, e_lat);
        end
        if (rsp_ready) begin
          o_nrsp++;
          last_status = 32'(rsp_status_o);
          last_dat    = rsp_dat_o;
          check("attempts", o_att, e_att);
          check("cyc_cycles", o_cyc, e_cyc);
          check("stb_cycles", o_stb, e_stb);
        end
      end
      if (cmd_valid && cmd_ready_o) begin
        lat = 0; o_att = 0; o_cyc = 0; o_stb = 0; o_rsp_cyc = 0; rsp_first = 1'b1;
      end
      prev_cyc = wb_cyc_o;
    end
  end

  task automatic clear_sc();
    for (int i = 0; i < 8; i++) begin
      sc_kind[i] = K_ACK; sc_t[i] = 1; sc_stall[i] = 0;
    end
  endtask

  task automatic set_sc(input int i, input int k, input int t, input int s);
    sc_kind[i] = k; sc_t[i] = t; sc_stall[i] = s;
  endtask

  // Issue one command and wait for its response; called at posedge+1.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input logic [31:0] rd);
    int n = 0;
    cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat;
    e_we = we; e_adr = adr; e_sel = sel; e_dat = dat;
    sc_rdata = rd; sl_att = -1;
    model(we, rd);
    cmd_valid = 1'b1;
    while (!cmd_ready_o && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready_o) bound_fail("cmd_handshake");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input logic [31:0] rd, input int hold);
    int n = 0;
    rsp_ready = (hold == 0);
    issue(we, adr, sel, dat, rd);
    while (!rsp_valid_o && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!rsp_valid_o) begin
      bound_fail("rsp_wait");
      return;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    sent++;
  endtask

  initial begin
    int k, r, n, nrsp0;
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, n, nrsp0;
    rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_sel = 0; cmd_dat = 0; rsp_ready = 0;
    clear_sc();
    sl_att = -1;
    #12;
    check("rst_cmd_ready", 32'(cmd_ready_o), 1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 0);
    check("rst_cyc", 32'(wb_cyc_o), 0);
    check("rst_stb", 32'(wb_stb_o), 0);
    check("rst_we", 32'(wb_we_o), 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_sel", 32'(wb_sel_o), 0);
    check("rst_rsp_dat", rsp_dat_o, 0);
    check("rst_rsp_status", 32'(rsp_status_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Zero-wait write, then read.
    clear_sc();
    send(1'b1, 32'h4, 4'hF, 32'hA5A5A5A5, 32'h0, 0);
    check("zw_write_stb", o_stb, 1);
    check("zw_write_status", last_status, 0);
    check("zw_write_lat", last_lat, 2);
    send(1'b0, 32'h4, 4'hF, 32'h0, 32'h00000015, 0);
    check("zw_read_dat", last_dat, 32'h15);
    check("zw_read_lat", last_lat, 2);

    // Stall until ack on the third stb cycle.
    clear_sc(); set_sc(0, K_ACK, 3, 2);
    nrsp0 = o_nrsp;
    send(1'b1, 32'h100, 4'h3, 32'h12345678, 32'h0, 0);
    check("stall_stb", o_stb, 3);
    check("stall_status", last_status, 0);
    check("stall_one_rsp", o_nrsp - nrsp0, 1);

    // Two retries then ack.
    clear_sc(); set_sc(0, K_RTY, 1, 0); set_sc(1, K_RTY, 1, 0); set_sc(2, K_ACK, 2, 0);
    send(1'b0, 32'h200, 4'hF, 32'h0, 32'hCAFEF00D, 0);
    check("rty2_attempts", o_att, 3);
    check("rty2_status", last_status, 0);
    check("rty2_dat", last_dat, 32'hCAFEF00D);

    // Retry exhausted.
    clear_sc();
    for (int i = 0; i < 8; i++) set_sc(i, K_RTY, 1, 0);
    send(1'b0, 32'h204, 4'hF, 32'h0, 32'hDEADBEEF, 0);
    check("rtyx_attempts", o_att, 4);
    check("rtyx_status", last_status, 2);
    check("rtyx_dat", last_dat, 0);

    // Error alone, and all three terminations together.
    clear_sc(); set_sc(0, K_ERR, 2, 0);
    send(1'b0, 32'h300, 4'hF, 32'h0, 32'h11111111, 0);
    check("err_status", last_status, 1);
    clear_sc(); set_sc(0, K_ALL, 1, 0);
    send(1'b0, 32'h304, 4'hF, 32'h0, 32'h22222222, 0);
    check("prio_status", last_status, 1);
    check("prio_dat", last_dat, 0);

    // Timeout, and an ack landing in the last allowed cycle.
    clear_sc(); set_sc(0, K_NONE, 1, 0);
    send(1'b0, 32'h400, 4'hF, 32'h0, 32'h33333333, 0);
    check("tmo_cyc", o_cyc, 8);
    check("tmo_status", last_status, 3);
    check("tmo_dat", last_dat, 0);
    clear_sc(); set_sc(0, K_ACK, 8, 0);
    send(1'b0, 32'h404, 4'hF, 32'h0, 32'h44444444, 0);
    check("tmo_edge_status", last_status, 0);
    check("tmo_edge_cyc", o_cyc, 8);

    // Response backpressure for 5 cycles.
    clear_sc();
    send(1'b1, 32'h500, 4'h1, 32'h55, 32'h0, 5);
    check("bp_rsp_cycles", o_rsp_cyc, 6);

    // Reset while waiting for a termination.
    clear_sc(); set_sc(0, K_NONE, 1, 0);
    rsp_ready = 1'b1;
    issue(1'b1, 32'h600, 4'hF, 32'h66, 32'h0);
    n = 0;
    while (!(wb_cyc_o && !wb_stb_o) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!(wb_cyc_o && !wb_stb_o)) bound_fail("reach_wait");
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_cyc", 32'(wb_cyc_o), 0);
    check("mid_rst_stb", 32'(wb_stb_o), 0);
    check("mid_rst_rsp_valid", 32'(rsp_valid_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", 32'(cmd_ready_o), 1);
    check("post_rst_rsp_valid", 32'(rsp_valid_o), 0);
    mon_en = 1'b1;

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      clear_sc();
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 9);
        sc_kind[i]  = (r <= 4) ? K_ACK : (r == 5) ? K_ERR : (r <= 7) ? K_RTY : (r == 8) ? K_ALL : K_NONE;
        sc_t[i]     = $urandom_range(1, 10);
        sc_stall[i] = $urandom_range(0, 4);
      end
      send(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom, $urandom,
           ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    end

    check("rsp_count", o_nrsp, sent);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
# wb_initiator

Single-outstanding Wishbone B4 pipelined bus initiator. It converts a valid/ready command stream (address, data, write-enable, byte-select) into one Wishbone cycle at a time. It captures the read data and termination status and returns them on a valid/ready response stream. It drives generated register-bank slaves from on-chip sequencers and bridges, and tolerates slaves that hold stall until ack.

## Interface
- ADDR_WIDTH, 32: byte-address width of cmd_adr_i / wb_adr_o.
- TIMEOUT, 255: cycles allowed from first stb to termination; range 1..65535.
- MAX_RETRY, 3: rty terminations re-issued before giving up; 0 = never re-issue.

- clk_i  in  1  single clock, all logic rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_adr_i  in  ADDR_WIDTH  byte address.
- cmd_we_i  in  1  1 = write.
- cmd_sel_i  in  4  byte selects.
- cmd_dat_i  in  32  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_dat_o  out  32  read data; 0 for writes and failed cycles.
- rsp_status_o  out  2  00 ack, 01 err, 10 retry exhausted, 11 timeout.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone controls.
- wb_adr_o  out  ADDR_WIDTH  address.
- wb_sel_o  out  4  byte selects.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1  slave responses.

## Operation
- States: IDLE, REQ, WAIT, BACKOFF, RSP.
- IDLE: cmd_ready_o=1. On handshake, register adr/we/sel/dat onto the wb_* outputs, clear the timeout counter and retry counter, and go to REQ.
- REQ: cyc=stb=1.
  - A termination (ack/err/rty) in this cycle is honoured regardless of stall.
  - Otherwise, if stall=0, go to WAIT.
  - Otherwise stay in REQ with address and data held stable.
- WAIT: cyc=1, stb=0. Wait for a termination.
- Termination priority when several are asserted together: err > rty > ack.
  - ack: rsp_dat_o <= wb_dat_i on a read, 0 on a write. Status 00. Go to RSP.
  - err: data 0, status 01, go to RSP.
  - rty with retry count < MAX_RETRY: increment the retry count, go to BACKOFF.
  - rty with retry count = MAX_RETRY: data 0, status 10, go to RSP.
- BACKOFF: cyc=stb=0 for exactly one cycle. Clear the timeout counter. Go to REQ with the same address and data.
- Timeout:
  - The 16-bit counter increments on every REQ/WAIT cycle without a termination.
  - When it reaches TIMEOUT, drop cyc/stb, set data 0 and status 11, and go to RSP.
  - A termination that arrives in that same cycle takes precedence over the timeout.
- RSP: rsp_valid_o=1, cyc=0, cmd_ready_o=0. On rsp_ready_i, go to IDLE.
- Terminations sampled while cyc=0 are ignored.
- wb_* data/address outputs keep their last value outside a cycle. No combinational path runs from wb_* inputs to wb_* outputs.

## Timing
- Reset (asynchronous, during and after): state IDLE.
  - cmd_ready_o=1, rsp_valid_o=0.
  - wb_cyc_o, wb_stb_o, wb_we_o = 0.
  - wb_adr_o, wb_sel_o, wb_dat_o, rsp_dat_o, rsp_status_o = 0.
  - All counters = 0.
- Reset mid-cycle drops cyc/stb immediately. The in-flight command and its response are lost.
- Command handshake at edge N puts stb on the bus during cycle N+1.
- Zero-wait slave (ack during the first stb cycle, N+1): rsp_valid_o during N+2.
- Next command accepted at the earliest one cycle after the rsp handshake (IDLE cycle).
- Throughput with a zero-wait slave and rsp_ready_i=1: one transaction per 3 cycles.
- rsp_dat_o and rsp_status_o are stable while rsp_valid_o=1.
- wb_stb_o is never asserted for more than one accepted transfer per command attempt.

## Test plan
- Zero-wait write, then read:
  - Write adr 0x4, dat 0xA5A5A5A5, sel F. Slave acks in the first stb cycle. Require stb high for exactly 1 cycle and status 00.
  - Read adr 0x4 with wb_dat_i=0x00000015. Require rsp_dat_o=0x15 two cycles after the command handshake.
- Stall-until-ack slave (stall = ~ack during stb, ack on the 3rd stb cycle):
  - Require stb high for 3 cycles with stable adr/dat.
  - Require exactly one response, status 00.
- Retry with MAX_RETRY=3:
  - Slave answers rty to 2 attempts, then ack. Require two 1-cycle cyc drops and final status 00.
  - Slave always answers rty. Require 4 attempts, then status 10 and rsp_dat_o=0.
- Error and priority:
  - err alone gives status 01.
  - err, rty and ack asserted in the same cycle give status 01.
- Timeout, TIMEOUT=8, slave never responds:
  - Require cyc to drop after 8 cycles of cyc, then status 11.
  - Ack arriving in the 8th cycle gives status 00 instead.
- Backpressure and reset:
  - Hold rsp_ready_i=0 for 5 cycles. Require rsp_valid_o held, cmd_ready_o=0 and no new cyc.
  - Assert rst_i while in WAIT. Require cyc=0 and rsp_valid_o=0 in that same cycle, and cmd_ready_o=1 after release.
